// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: active-high glyphs
// in {g,f,e,d,c,b,a} order and the digit-slot indices.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Slot index doubles as the anode bit position.
    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [1:0] DIG_SIGN = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high 7-segment glyph; non-BCD values show E, and the
// blank flag overrides everything with an unlit digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);

    // Glyph lookup with blank override.
    always_comb begin
        // NOTE: every path assigns glyph, with E as the default, so no latch is inferred.
        glyph = SEG_E;
        if (blank) begin
            glyph = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    glyph = SEG_0;
                4'd1:    glyph = SEG_1;
                4'd2:    glyph = SEG_2;
                4'd3:    glyph = SEG_3;
                4'd4:    glyph = SEG_4;
                4'd5:    glyph = SEG_5;
                4'd6:    glyph = SEG_6;
                4'd7:    glyph = SEG_7;
                4'd8:    glyph = SEG_8;
                4'd9:    glyph = SEG_9;
                default: glyph = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit display driver: captures a sign/BCD value on
// data_ready, scans sign/hundreds/tens/ones with leading-zero blanking and
// an all-anodes-off guard interval at the start of every slot.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sign,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       data_ready,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  GUARD_C  = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          lat_sign;
    logic [3:0]    lat_hund;
    logic [3:0]    lat_tens;
    logic [3:0]    lat_ones;
    logic          have_data;

    logic          guard_done;
    logic [3:0]    dig_nib;
    logic          dig_blank;
    logic [6:0]    dec_glyph;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // With no guard the compare would be constant-true, so elide it.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_done = 1'b1;
        end else begin : g_guard
            assign guard_done = (cnt >= GUARD_C);
        end
    endgenerate

    // Slot counter and digit index; idx advances when cnt wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt <= '0;
            idx <= DIG_ONES;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture the converter result whenever data_ready is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_sign  <= 1'b0;
            lat_hund  <= 4'h0;
            lat_tens  <= 4'h0;
            lat_ones  <= 4'h0;
            have_data <= 1'b0;
        end else if (data_ready) begin
            lat_sign  <= sign;
            lat_hund  <= hundreds;
            lat_tens  <= tens;
            lat_ones  <= ones;
            have_data <= 1'b1;
        end
    end

    // Per-slot digit mux with leading-zero blanking.
    always_comb begin
        dig_nib   = lat_ones;
        dig_blank = 1'b0;
        unique case (idx)
            DIG_ONES: begin
                dig_nib   = lat_ones;
                dig_blank = 1'b0;
            end
            DIG_TENS: begin
                dig_nib   = lat_tens;
                dig_blank = (lat_hund == 4'h0) && (lat_tens == 4'h0);
            end
            DIG_HUND: begin
                dig_nib   = lat_hund;
                dig_blank = (lat_hund == 4'h0);
            end
            default: begin
                dig_nib   = 4'h0;
                dig_blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_decode (
        .nibble (dig_nib),
        .blank  (dig_blank),
        .glyph  (dec_glyph)
    );

    // Next segment/anode values; the sign slot bypasses the decoder.
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = 4'b0000;
        if (have_data) begin
            if (idx == DIG_SIGN) begin
                seg_next = lat_sign ? SEG_MINUS : SEG_BLANK;
            end else begin
                seg_next = dec_glyph;
            end
            if (guard_done) begin
                an_next = 4'b0001 << idx;
            end
        end
    end

    // Output registers with board polarity applied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
            an  <= ACTIVE_LOW ? 4'hF : 4'h0;
        end else begin
            seg <= ACTIVE_LOW ? ~seg_next : seg_next;
            an  <= ACTIVE_LOW ? ~an_next : an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (REFRESH_DIV=8, GUARD=2, ACTIVE_LOW=1).
// The stimulus side pushes the expected registered outputs for every edge;
// a negedge monitor pops and compares them against the DUT.
module tb_seg7_scan;

    localparam int RDIV  = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * RDIV;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       seg_care;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       data_ready;
    logic [6:0] seg;
    logic [3:0] an;

    exp_t       sb[$];
    int         checks;
    int         errors;
    int         cyc;

    // Expected-display state: position in the frame, data flag, and the
    // hand-supplied active-high glyph for each slot (index = anode bit).
    int         p;
    bit         m_have;
    logic [6:0] m_g   [4];
    logic [6:0] pend_g[4];

    seg7_scan #(
        .REFRESH_DIV (RDIV),
        .GUARD       (GRD),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sign       (sign),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .data_ready (data_ready),
        .seg        (seg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int c, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, c, got, want);
        end
    endtask

    // Monitor: one registered output per edge, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("an", e.cyc, {7'h0, an}, {7'h0, e.an});
            if (e.seg_care) check("seg", e.cyc, {4'h0, seg}, {4'h0, e.seg});
        end
    end

    // One clock edge: push what the outputs must show after it, then move
    // inputs away from the edge.
    task automatic tick();
        exp_t e;
        int   slot;
        int   pos;
        @(posedge clk);
        cyc++;
        e.cyc = cyc;
        if (!rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.seg_care = 1'b1;
            p = 0;
            m_have = 1'b0;
            for (int i = 0; i < 4; i++) m_g[i] = 7'h00;
        end else begin
            slot = p / RDIV;
            pos  = p % RDIV;
            if (m_have) begin
                e.an       = (pos >= GRD) ? ~(4'b0001 << slot) : 4'hF;
                e.seg      = ~m_g[slot];
                e.seg_care = (pos >= GRD);
            end else begin
                e.an = 4'hF; e.seg = 7'h7F; e.seg_care = 1'b1;
            end
            p = (p + 1) % FRAME;
            if (data_ready) begin
                m_have = 1'b1;
                for (int i = 0; i < 4; i++) m_g[i] = pend_g[i];
            end
        end
        sb.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle data_ready pulse with the glyphs the slots must then show.
    task automatic capture(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic [6:0] g_sign, input logic [6:0] g_hund,
                           input logic [6:0] g_tens, input logic [6:0] g_ones);
        sign = s; hundreds = h; tens = t; ones = o;
        pend_g[0] = g_ones; pend_g[1] = g_tens; pend_g[2] = g_hund; pend_g[3] = g_sign;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < FRAME && p != target; i++) tick();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; p = 0; m_have = 1'b0;
        for (int i = 0; i < 4; i++) begin m_g[i] = 7'h00; pend_g[i] = 7'h00; end
        rst = 1'b0; sign = 1'b0; hundreds = 4'h0; tens = 4'h0; ones = 4'h0; data_ready = 1'b0;

        // Reset, then idle with no data: everything dark.
        run(3);
        rst = 1'b1;
        run(100);

        // +123
        capture(1'b0, 4'd1, 4'd2, 4'd3, 7'h00, 7'h06, 7'h5B, 7'h4F);
        run(FRAME + 4);

        // -5: tens/hundreds blanked, minus in sign slot; captured at a slot boundary
        run_until(RDIV - 1);
        capture(1'b1, 4'd0, 4'd0, 4'd5, 7'h40, 7'h00, 7'h00, 7'h6D);
        run(FRAME + 2);

        // 0: only the ones digit lit
        capture(1'b0, 4'd0, 4'd0, 4'd0, 7'h00, 7'h00, 7'h00, 7'h3F);
        run(FRAME);

        // Non-BCD tens with hundreds=1 -> E in tens slot
        capture(1'b0, 4'd1, 4'hA, 4'd7, 7'h00, 7'h06, 7'h79, 7'h07);
        run(FRAME);

        // Non-BCD tens with hundreds=0 is not blanked; non-BCD ones -> E
        capture(1'b1, 4'd0, 4'hC, 4'hF, 7'h40, 7'h00, 7'h79, 7'h79);
        run(FRAME);

        // Hold: inputs change without data_ready, display keeps last value
        sign = 1'b1; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
        run(FRAME);

        // Capture mid ones-slot: new glyph one clock after the capture edge
        run_until(4);
        capture(1'b1, 4'd9, 4'd9, 4'd9, 7'h40, 7'h6F, 7'h6F, 7'h6F);
        run(FRAME);

        // Reset mid hundreds-slot, with data_ready high at the same edge
        run_until(2 * RDIV + 3);
        rst = 1'b0;
        capture(1'b0, 4'd4, 4'd5, 4'd6, 7'h00, 7'h66, 7'h6D, 7'h7D);
        rst = 1'b1;
        run(FRAME + 8);

        // Fresh capture after reset restarts normal display
        capture(1'b0, 4'd0, 4'd8, 4'd2, 7'h00, 7'h00, 7'h7F, 7'h5B);
        run(FRAME);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
